// File: rtl/serv_ram_responder.sv
// serv_ram_responder: Wishbone-classic responder sharing one RAM32 port between SERV ibus and dbus
// Ports: clk, rst_n (async active-low); ibus cyc/adr in, rdt/ack out; dbus cyc/adr/we/dat/sel in,
// rdt/ack out; RAM32 port en/a/we/di out, do in; o_oor sticky out-of-range flag.
// Optional: define SERV_RAM_OOR_ERR_EN to flag and block accesses above the RAM (else addresses alias).
module serv_ram_responder #(
  parameter int ADDR_W = 5,
  parameter bit DBUS_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ibus_cyc,
  input  logic [31:0]       i_ibus_adr,
  output logic [31:0]       o_ibus_rdt,
  output logic              o_ibus_ack,
  input  logic              i_dbus_cyc,
  input  logic [31:0]       i_dbus_adr,
  input  logic              i_dbus_we,
  input  logic [31:0]       i_dbus_dat,
  input  logic [3:0]        i_dbus_sel,
  output logic [31:0]       o_dbus_rdt,
  output logic              o_dbus_ack,
  output logic              o_ram_en,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic [3:0]        o_ram_we,
  output logic [31:0]       o_ram_di,
  input  logic [31:0]       i_ram_do,
  output logic              o_oor
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nx;
  logic req, sel_d, oor_sel, gnt_d, gnt_wr, gnt_oor;
  logic [31:0] adr, rd;
  logic unused;
  assign req = i_ibus_cyc | i_dbus_cyc;
  assign sel_d = i_dbus_cyc & (DBUS_PRIO ? 1'b1 : !i_ibus_cyc);
  assign adr = sel_d ? i_dbus_adr : i_ibus_adr;
  assign unused = &{1'b0, adr[1:0], adr[31:ADDR_W+2]};
`ifdef SERV_RAM_OOR_ERR_EN
  logic oor_q;
  assign oor_sel = |adr[31:ADDR_W+2];
  assign o_oor = oor_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) oor_q <= 1'b0;
    else if (state == IDLE && req && oor_sel) oor_q <= 1'b1;
`else
  assign oor_sel = 1'b0;
  assign o_oor = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt_d <= 1'b0;
      gnt_wr <= 1'b0;
      gnt_oor <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        gnt_d <= sel_d;
        gnt_wr <= sel_d & i_dbus_we;
        gnt_oor <= oor_sel;
      end
    end
  // rst_n gates the RAM enable so a request held during reset never touches the macro
  always_comb begin
    state_nx = IDLE;
    o_ram_en = 1'b0;
    o_ram_we = 4'b0;
    o_ram_a = adr[ADDR_W+1:2];
    o_ram_di = i_dbus_dat;
    if (state == IDLE) begin
      state_nx = req ? ACK : IDLE;
      o_ram_en = rst_n & req & !oor_sel;
      o_ram_we = (o_ram_en & sel_d & i_dbus_we) ? i_dbus_sel : 4'b0;
    end
    o_ibus_ack = (state == ACK) & !gnt_d;
    o_dbus_ack = (state == ACK) & gnt_d;
    rd = (state == ACK && !gnt_wr && !gnt_oor) ? i_ram_do : 32'b0;
    o_ibus_rdt = o_ibus_ack ? rd : 32'b0;
    o_dbus_rdt = o_dbus_ack ? rd : 32'b0;
  end
endmodule

// File: tb/tb_serv_ram_responder.sv
// tb_serv_ram_responder: randomized self-checking bench against a word-level memory model
module tb_serv_ram_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ibus_cyc = 0, ibus_ack, dbus_cyc = 0, dbus_we = 0, dbus_ack, ram_en, oor;
  logic [31:0] ibus_adr = 0, ibus_rdt, dbus_adr = 0, dbus_dat = 0, dbus_rdt, ram_di, ram_do = 0;
  logic [3:0] dbus_sel = 0, ram_we;
  logic [4:0] ram_a;
  logic [31:0] ram [32];
  logic [31:0] ref_mem [32];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serv_ram_responder #(.ADDR_W(5), .DBUS_PRIO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ibus_cyc(ibus_cyc), .i_ibus_adr(ibus_adr), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_cyc(dbus_cyc), .i_dbus_adr(dbus_adr), .i_dbus_we(dbus_we), .i_dbus_dat(dbus_dat),
    .i_dbus_sel(dbus_sel), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .o_ram_en(ram_en), .o_ram_a(ram_a), .o_ram_we(ram_we), .o_ram_di(ram_di), .i_ram_do(ram_do),
    .o_oor(oor)
  );
  // RAM32 macro stand-in: one-cycle read latency, read-before-write, per-byte write enables
  always @(posedge clk)
    if (ram_en) begin
      ram_do = ram[ram_a];
      for (int b = 0; b < 4; b++) if (ram_we[b]) ram[ram_a][8*b +: 8] = ram_di[8*b +: 8];
    end
  function automatic bit is_oor(input logic [31:0] adr);
`ifdef SERV_RAM_OOR_ERR_EN
    return adr[31:7] != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] exp_read(input logic [31:0] adr);
    return is_oor(adr) ? 32'h0 : ref_mem[adr[6:2]];
  endfunction
  function automatic void ref_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (!is_oor(adr))
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[adr[6:2]][8*b +: 8] = dat[8*b +: 8];
  endfunction
  // One complete transaction starting in IDLE at posedge+1; returns what was seen in cycle N and N+1
  task automatic access(input bit d, input logic [31:0] adr, input bit we, input logic [31:0] dat,
                        input logic [3:0] sel, output logic en, output logic [4:0] a,
                        output logic [3:0] rwe, output logic ack, output logic oack, output logic [31:0] rdt);
    if (d) begin dbus_cyc = 1; dbus_adr = adr; dbus_we = we; dbus_dat = dat; dbus_sel = sel; end
    else begin ibus_cyc = 1; ibus_adr = adr; end
    @(negedge clk); en = ram_en; a = ram_a; rwe = ram_we;
    @(posedge clk); #1; ibus_cyc = 0; dbus_cyc = 0;
    @(negedge clk); ack = d ? dbus_ack : ibus_ack; oack = d ? ibus_ack : dbus_ack; rdt = d ? dbus_rdt : ibus_rdt;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    ibus_cyc = 1; dbus_cyc = 1; dbus_we = 1; dbus_sel = 4'hF;
    @(negedge clk);
    checks++; if (ibus_ack !== 0 || dbus_ack !== 0) begin errors++; $display("FAIL reset_ack: got %b%b expected 00", ibus_ack, dbus_ack); end
    checks++; if (ibus_rdt !== 0 || dbus_rdt !== 0) begin errors++; $display("FAIL reset_rdt: got %h %h expected 0", ibus_rdt, dbus_rdt); end
    checks++; if (ram_en !== 0 || ram_we !== 0) begin errors++; $display("FAIL reset_ram: got en=%b we=%h expected 0", ram_en, ram_we); end
    checks++; if (oor !== 0) begin errors++; $display("FAIL reset_oor: got %b expected 0", oor); end
    ibus_cyc = 0; dbus_cyc = 0; dbus_we = 0; rst_n = 1;
    @(negedge clk);
    checks++; if (ram_en !== 0 || ibus_ack !== 0 || dbus_ack !== 0) begin errors++; $display("FAIL post_reset_idle: got en=%b acks=%b%b expected 0", ram_en, ibus_ack, dbus_ack); end
    @(posedge clk); #1;
  endtask
  task automatic test_write_read;
    logic en, ack, oack; logic [4:0] a; logic [3:0] rwe; logic [31:0] rdt;
    access(1, 32'h8, 1, 32'hDEADBEEF, 4'hF, en, a, rwe, ack, oack, rdt); ref_write(32'h8, 32'hDEADBEEF, 4'hF);
    checks++; if (en !== 1 || a !== 5'd2 || rwe !== 4'hF) begin errors++; $display("FAIL wr_port: got en=%b a=%0d we=%h expected 1 2 f", en, a, rwe); end
    checks++; if (ack !== 1 || oack !== 0 || rdt !== 0) begin errors++; $display("FAIL wr_ack: got ack=%b other=%b rdt=%h expected 1 0 0", ack, oack, rdt); end
    access(0, 32'h8, 0, 0, 0, en, a, rwe, ack, oack, rdt);
    checks++; if (en !== 1 || rwe !== 0) begin errors++; $display("FAIL rd_port: got en=%b we=%h expected 1 0", en, rwe); end
    checks++; if (ack !== 1 || oack !== 0 || rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got ack=%b other=%b rdt=%h expected 1 0 deadbeef", ack, oack, rdt); end
  endtask
  task automatic test_byte_lanes;
    logic en, ack, oack; logic [4:0] a; logic [3:0] rwe; logic [31:0] rdt;
    access(1, 32'hC, 1, 32'h11223344, 4'hF, en, a, rwe, ack, oack, rdt); ref_write(32'hC, 32'h11223344, 4'hF);
    access(1, 32'hD, 1, 32'h0000AA00, 4'h2, en, a, rwe, ack, oack, rdt); ref_write(32'hD, 32'h0000AA00, 4'h2);
    checks++; if (rwe !== 4'h2 || a !== 5'd3) begin errors++; $display("FAIL lane_we: got we=%h a=%0d expected 2 3", rwe, a); end
    access(1, 32'hC, 1, 32'hFFFFFFFF, 4'h0, en, a, rwe, ack, oack, rdt);
    checks++; if (ack !== 1 || rwe !== 0) begin errors++; $display("FAIL sel0_write: got ack=%b we=%h expected 1 0", ack, rwe); end
    access(1, 32'hC, 0, 0, 0, en, a, rwe, ack, oack, rdt);
    checks++; if (rdt !== 32'h1122AA44) begin errors++; $display("FAIL lane_readback: got %h expected 1122aa44", rdt); end
  endtask
  task automatic test_simultaneous;
    logic [31:0] dat = $urandom;
    ibus_cyc = 1; ibus_adr = 32'h10; dbus_cyc = 1; dbus_adr = 32'h10; dbus_we = 1; dbus_dat = dat; dbus_sel = 4'hF;
    ref_write(32'h10, dat, 4'hF);
    @(negedge clk);
    checks++; if (ram_we !== 4'hF || ram_a !== 5'd4) begin errors++; $display("FAIL tie_grant: got we=%h a=%0d expected f 4", ram_we, ram_a); end
    @(posedge clk); #1; dbus_cyc = 0;
    @(negedge clk);
    checks++; if (dbus_ack !== 1 || ibus_ack !== 0) begin errors++; $display("FAIL tie_first: got d=%b i=%b expected 1 0", dbus_ack, ibus_ack); end
    @(negedge clk);
    checks++; if (dbus_ack !== 0 || ibus_ack !== 0 || ram_en !== 1 || ram_we !== 0) begin errors++; $display("FAIL tie_gap: got d=%b i=%b en=%b we=%h expected 0 0 1 0", dbus_ack, ibus_ack, ram_en, ram_we); end
    @(posedge clk); #1; ibus_cyc = 0;
    @(negedge clk);
    checks++; if (ibus_ack !== 1 || ibus_rdt !== exp_read(32'h10)) begin errors++; $display("FAIL tie_second: got ack=%b rdt=%h expected 1 %h", ibus_ack, ibus_rdt, exp_read(32'h10)); end
    @(posedge clk); #1; dbus_we = 0;
  endtask
  task automatic test_back_to_back;
    int acks = 0; bit prev = 0;
    ibus_adr = {25'b0, 5'($urandom), 2'b0}; ibus_cyc = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (ibus_ack === 1 && prev) begin errors++; $display("FAIL b2b_width: got two consecutive acks at cycle %0d expected single", i); end
      checks++; if (ibus_ack === 1 && ibus_rdt !== exp_read(ibus_adr)) begin errors++; $display("FAIL b2b_data: got %h expected %h", ibus_rdt, exp_read(ibus_adr)); end
      prev = ibus_ack; acks += (ibus_ack === 1) ? 1 : 0;
    end
    ibus_cyc = 0;
    checks++; if (acks != 6) begin errors++; $display("FAIL b2b_rate: got %0d acks expected 6", acks); end
    @(posedge clk); #1;
  endtask
  task automatic test_oor;
    logic en, ack, oack; logic [4:0] a; logic [3:0] rwe; logic [31:0] rdt;
    access(0, 32'h100, 0, 0, 0, en, a, rwe, ack, oack, rdt);
`ifdef SERV_RAM_OOR_ERR_EN
    checks++; if (en !== 0 || ack !== 1 || rdt !== 0 || oor !== 1) begin errors++; $display("FAIL oor_access: got en=%b ack=%b rdt=%h oor=%b expected 0 1 0 1", en, ack, rdt, oor); end
    access(0, 32'h4, 0, 0, 0, en, a, rwe, ack, oack, rdt);
    checks++; if (oor !== 1) begin errors++; $display("FAIL oor_sticky: got %b expected 1", oor); end
`else
    checks++; if (en !== 1 || a !== 0 || ack !== 1 || rdt !== ref_mem[0] || oor !== 0) begin errors++; $display("FAIL alias: got en=%b a=%0d rdt=%h oor=%b expected 1 0 %h 0", en, a, rdt, oor, ref_mem[0]); end
`endif
  endtask
  task automatic test_random;
    logic en, ack, oack; logic [4:0] a; logic [3:0] rwe; logic [31:0] rdt, adr, dat, exp; logic [3:0] sel; bit d, we;
    for (int i = 0; i < 80; i++) begin
      d = 1'($urandom); we = d & 1'($urandom); dat = $urandom; sel = 4'($urandom);
      adr = $urandom;
      if ($urandom_range(0, 3) != 0) adr[31:7] = 0;
      exp = we ? 32'h0 : exp_read(adr);
      access(d, adr, we, dat, sel, en, a, rwe, ack, oack, rdt);
      if (we) ref_write(adr, dat, sel);
      checks++; if (en !== !is_oor(adr) || (en && a !== adr[6:2])) begin errors++; $display("FAIL rnd_port: got en=%b a=%0d expected %b %0d", en, a, !is_oor(adr), adr[6:2]); end
      checks++; if (rwe !== ((we && !is_oor(adr)) ? sel : 4'h0)) begin errors++; $display("FAIL rnd_we: got %h adr=%h sel=%h we=%b", rwe, adr, sel, we); end
      checks++; if (ack !== 1 || oack !== 0 || rdt !== exp) begin errors++; $display("FAIL rnd_resp: got ack=%b other=%b rdt=%h expected 1 0 %h", ack, oack, rdt, exp); end
    end
  endtask
  task automatic test_async_reset;
    dbus_cyc = 1; dbus_adr = 32'h14; dbus_we = 0;
    @(posedge clk); #2;
    checks++; if (dbus_ack !== 1) begin errors++; $display("FAIL arst_pre: got ack=%b expected 1", dbus_ack); end
    rst_n = 0; #1;
    checks++; if (dbus_ack !== 0 || ibus_ack !== 0 || dbus_rdt !== 0) begin errors++; $display("FAIL arst_drop: got ack=%b rdt=%h expected 0 0", dbus_ack, dbus_rdt); end
    @(negedge clk);
    checks++; if (ram_en !== 0) begin errors++; $display("FAIL arst_en: got %b expected 0", ram_en); end
    dbus_cyc = 0; rst_n = 1;
    @(negedge clk);
    checks++; if (ram_en !== 0 || dbus_ack !== 0 || oor !== 0) begin errors++; $display("FAIL arst_idle: got en=%b ack=%b oor=%b expected 0 0 0", ram_en, dbus_ack, oor); end
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 32; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    repeat (2) @(posedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_simultaneous();
    test_back_to_back();
    test_oor();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
